// File: rtl/add_requester.sv
// Initiator for a start/valid adder: one start pulse per accepted operand pair, result presented on ready/valid.
// Polices the adder with a WAIT timeout and a sticky spurious-valid flag. ADD_REQ_CHECK_EN adds a sum checker.
module add_requester #(
  parameter int W       = 10,
  parameter int TIMEOUT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  output logic             start,
  output logic [W-1:0]     a,
  output logic [W-1:0]     b,
  input  logic [W-1:0]     y,
  input  logic             valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_y,
  output logic             out_timeout,
`ifdef ADD_REQ_CHECK_EN
  output logic             mismatch,
`endif
  output logic             spurious,
  output logic [CNT_W-1:0] txn_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t        state;
  logic [TW-1:0] wait_cnt;

  // Gated by rst so upstream never sees a handshake while reset is held.
  assign in_ready = (state == IDLE) && !rst;

`ifdef ADD_REQ_CHECK_EN
  logic [W-1:0] exp_sum;
  assign exp_sum = a + b;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      start       <= 1'b0;
      a           <= '0;
      b           <= '0;
      out_valid   <= 1'b0;
      out_y       <= '0;
      out_timeout <= 1'b0;
      spurious    <= 1'b0;
      txn_count   <= '0;
      wait_cnt    <= '0;
`ifdef ADD_REQ_CHECK_EN
      mismatch    <= 1'b0;
`endif
    end else begin
      // Any adder valid outside WAIT, including a late one after timeout, is a protocol error.
      if (valid && state != WAIT)
        spurious <= 1'b1;

      case (state)
        IDLE: begin
          if (in_valid) begin
            a     <= in_a;
            b     <= in_b;
            start <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          start    <= 1'b0;
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (valid) begin
            out_y       <= y;
            out_timeout <= 1'b0;
            out_valid   <= 1'b1;
            state       <= HOLD;
`ifdef ADD_REQ_CHECK_EN
            mismatch    <= (y != exp_sum);
`endif
          end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            out_y       <= '0;
            out_timeout <= 1'b1;
            out_valid   <= 1'b1;
            state       <= HOLD;
`ifdef ADD_REQ_CHECK_EN
            mismatch    <= 1'b0;
`endif
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            txn_count <= txn_count + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_requester.sv
// Scoreboard bench for add_requester with a behavioural single-cycle adder.
module tb_add_requester;
  localparam int W = 10;
  localparam int TIMEOUT = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a, in_b;
  logic             start;
  logic [W-1:0]     dut_a, dut_b;
  logic [W-1:0]     adder_y;
  logic             adder_valid;
  logic             inj_valid;
  logic             valid;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_y;
  logic             out_timeout;
  logic             spurious;
  logic [CNT_W-1:0] txn_count;
`ifdef ADD_REQ_CHECK_EN
  logic             mismatch;
`endif

  logic             adder_en;
  logic             force_en;
  logic [W-1:0]     force_y;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [W-1:0] y;
    logic         to;
    logic         mm;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  add_requester #(.W(W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .start(start), .a(dut_a), .b(dut_b), .y(adder_y), .valid(valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_timeout(out_timeout),
`ifdef ADD_REQ_CHECK_EN
    .mismatch(mismatch),
`endif
    .spurious(spurious), .txn_count(txn_count)
  );

  // Behavioural adder: valid one cycle after start, y = a+b unless overridden.
  always @(posedge clk) begin
    adder_valid <= start & adder_en;
    adder_y     <= force_en ? force_y : W'(dut_a + dut_b);
  end
  assign valid = adder_valid | inj_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every downstream handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_result", 32'(out_y), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_y", 32'(out_y), 32'(e.y));
        chk("out_timeout", 32'(out_timeout), 32'(e.to));
`ifdef ADD_REQ_CHECK_EN
        chk("mismatch", 32'(mismatch), 32'(e.mm));
`endif
      end
    end
  end

  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb,
                      input logic [W-1:0] ey, input logic eto, input logic emm, input bit push);
    int n;
    exp_t e;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a = va;
    in_b = vb;
    if (push) begin
      e.y = ey; e.to = eto; e.mm = emm;
      sb.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("idle_wait", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int c;
    logic [CNT_W-1:0] txn_before;
    rst = 1'b1; in_valid = 1'b1; in_a = 10'd5; in_b = 10'd6;
    out_ready = 1'b1; adder_en = 1'b1; force_en = 1'b0; force_y = '0; inj_valid = 1'b0;

    // Reset held 3 cycles with in_valid asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("rst_start", 32'(start), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_txn", 32'(txn_count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
    end
    tick();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Nominal 300+200 with cycle-exact latency
    send(10'd300, 10'd200, 10'd500, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("nom_start_n1", 32'(start), 32'd1);
    chk("nom_a", 32'(dut_a), 32'd300);
    chk("nom_b", 32'(dut_b), 32'd200);
    chk("nom_in_ready_n1", 32'(in_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("nom_start_n2", 32'(start), 32'd0);
    chk("nom_out_valid_n2", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("nom_out_valid_n3", 32'(out_valid), 32'd1);
    tick();
    @(negedge clk);
    chk("nom_in_ready_n4", 32'(in_ready), 32'd1);
    chk("nom_out_valid_n4", 32'(out_valid), 32'd0);
    chk("nom_txn", 32'(txn_count), 32'd1);
    tick();

    // Wrap arithmetic 1023+2 -> 1, then a wrong adder answer
    send(10'd1023, 10'd2, 10'd1, 1'b0, 1'b0, 1'b1);
    wait_idle();
    force_en = 1'b1; force_y = 10'd2;
    send(10'd1023, 10'd2, 10'd2, 1'b0, 1'b1, 1'b1);
    wait_idle();
    force_en = 1'b0;
    chk("wrap_txn", 32'(txn_count), 32'd3);

    // Timeout: adder silent, out_valid 4 cycles after WAIT entry (6 after handshake)
    adder_en = 1'b0;
    send(10'd7, 10'd8, 10'd0, 1'b1, 1'b0, 1'b1);
    c = 1;
    while (c < 30) begin
      @(negedge clk);
      if (out_valid) break;
      tick();
      c++;
    end
    chk("timeout_latency", 32'(c), 32'd6);
    chk("spurious_before", 32'(spurious), 32'd0);
    wait_idle();
    inj_valid = 1'b1;
    tick();
    inj_valid = 1'b0;
    @(negedge clk);
    chk("spurious_late_valid", 32'(spurious), 32'd1);
    chk("timeout_txn", 32'(txn_count), 32'd4);
    tick();

    // Backpressure: HOLD for 5 cycles while upstream keeps offering
    adder_en = 1'b1; out_ready = 1'b0;
    send(10'd100, 10'd50, 10'd150, 1'b0, 1'b0, 1'b1);
    c = 0;
    while (!out_valid && c < 20) begin
      tick();
      c++;
    end
    txn_before = txn_count;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 10'd1; in_b = 10'd1;
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_y", 32'(out_y), 32'd150);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_txn", 32'(txn_count), 32'd4);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("bp_release_txn", 32'(txn_count), 32'(txn_before) + 32'd1);
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    tick();

    // Reset during WAIT
    adder_en = 1'b0;
    send(10'd9, 10'd9, 10'd0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_spurious", 32'(spurious), 32'd0);
    chk("mrst_txn", 32'(txn_count), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);
    chk("mrst_start", 32'(start), 32'd0);
    tick();
    adder_en = 1'b1;
    send(10'd12, 10'd34, 10'd46, 1'b0, 1'b0, 1'b1);
    wait_idle();
    @(negedge clk);
    chk("mrst_after_txn", 32'(txn_count), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop against a hung handshake
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got hang expected completion");
    $fatal(1);
  end

endmodule

// File: doc/add_requester.md
Name: add_requester

Overview:
Initiator side of the start/valid adder handshake. Accepts operand pairs from an upstream ready/valid stream and issues one start pulse per pair to a single-cycle-latency adder. It waits for the adder's valid, captures y and presents the result downstream on a ready/valid stream. Adds timeout detection, spurious-valid detection and a transaction counter, so the adder can be driven and policed from RTL instead of only from a bench.

Parameters:
W, 10, operand/result width in bits
TIMEOUT, 4, max cycles spent in WAIT before declaring timeout (>=1)
CNT_W, 16, width of transaction counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream operand pair valid
in_ready  out  1  requester can accept a pair
in_a  in  W  operand a
in_b  in  W  operand b
start  out  1  one-cycle request pulse to adder
a  out  W  operand a to adder
b  out  W  operand b to adder
y  in  W  adder result
valid  in  1  adder result valid
out_valid  out  1  result available downstream
out_ready  in  1  downstream accepts result
out_y  out  W  captured result (0 on timeout)
out_timeout  out  1  result is a timeout marker, not data
spurious  out  1  sticky: valid seen outside WAIT
txn_count  out  CNT_W  completed transactions (wraps)

Behaviour:
- Clock clk. Reset rst is synchronous, active-high, sampled on posedge clk.
- Reset values: state=IDLE, start=0, a=0, b=0, out_valid=0, out_y=0, out_timeout=0, spurious=0, txn_count=0, wait counter=0. in_ready=1 on the first cycle after reset deasserts.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE: in_ready=1. On in_valid, capture in_a/in_b into a/b and go to ISSUE.
- ISSUE: start=1 for exactly one cycle, with a/b stable. Go to WAIT and clear the wait counter.
- WAIT: start=0.
  - valid=1 -> capture y into out_y, set out_timeout=0, go to HOLD.
  - Else, if counter==TIMEOUT-1 -> set out_y=0 and out_timeout=1, go to HOLD.
  - Else increment the counter.
  - valid has priority over timeout in the same cycle.
- HOLD: out_valid=1; out_y and out_timeout are held stable. On out_ready: out_valid drops next cycle, txn_count increments (timeouts included), go to IDLE.
- in_ready=0 in ISSUE, WAIT and HOLD. a/b hold their last values outside IDLE capture.
- Latency with a correct adder and out_ready=1:
  - in handshake at cycle N
  - start at N+1
  - valid at N+2
  - out_valid at N+3
  - in_ready again at N+4
- Throughput: one pair per 4 cycles.
- Counter width is $clog2(TIMEOUT+1).
- spurious: set when valid=1 in any state other than WAIT, including a late valid after a timeout. It stays set until rst; it does not affect the FSM.
- txn_count wraps from 2^CNT_W-1 to 0.
- Reset mid-transaction (any state) returns everything to reset values next cycle. The pending pair and result are dropped and txn_count is not incremented.

Optional Feature:
Macro ADD_REQ_CHECK_EN.
- Defined:
  - Adds output mismatch (1 bit), valid with out_valid.
  - In WAIT, on valid, mismatch is set when y != (a+b) truncated to W bits; otherwise 0.
  - mismatch is 0 on timeout and after reset.
- Not defined: the port is absent and no comparator logic is built.

Test Plan:
- Reset: hold rst=1 3 cycles with in_valid=1 -> start=0, out_valid=0, txn_count=0, in_ready=0 during reset, in_ready=1 the cycle after release.
- Nominal: in_a=300, in_b=200, adder model returns valid 1 cycle after start with y=500 -> start at N+1 with a=300/b=200, out_valid at N+3 with out_y=500, out_timeout=0, txn_count=1 after out_ready.
- Wrap arithmetic: in_a=1023, in_b=2 (W=10), y=1 -> out_y=1. With ADD_REQ_CHECK_EN, mismatch=0; forcing y=2 gives mismatch=1.
- Timeout: adder never raises valid -> out_valid rises exactly TIMEOUT cycles after WAIT entry with out_y=0, out_timeout=1. A later valid pulse sets spurious=1.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid/out_y stable, in_ready=0, in_valid ignored, txn_count unchanged until out_ready=1.
- Mid-operation reset: rst=1 during WAIT -> next cycle state IDLE, out_valid=0, spurious=0, txn_count=0; a following pair completes normally.
